clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- div_ratio_wd, 8, width of every ratio port.
- SETTLE, 4, number of cycles clk_en_o is held low before a ratio update; legal range is 1 to 255.
- RESET_RATIO, 1, value of div_ratio_o after reset; 1 selects divider bypass.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_ref, in, 1, the single clock; all logic is on its rising edge.
- rst, in, 1, reset, synchronous and active-high.
- run_en, in, 1, software enable for the downstream divider.
- req_a, in, 1, ratio-change request from requester A; level, held until ack_a.
- ratio_a, in, div_ratio_wd, ratio requested by A; valid while req_a is high.
- req_b, in, 1, ratio-change request from requester B; level, held until ack_b.
- ratio_b, in, div_ratio_wd, ratio requested by B; valid while req_b is high.
- ack_a, out, 1, one-cycle completion pulse to A.
- ack_b, out, 1, one-cycle completion pulse to B.
- busy, out, 1, high while a change sequence is in progress.
- clk_en_o, out, 1, drives the divider clock-enable input.
- div_ratio_o, out, div_ratio_wd, drives the divider ratio input.

REQ-003 ack_a, ack_b, clk_en_o and div_ratio_o SHALL be registered; busy SHALL be decoded combinationally as (state != IDLE).

Function
REQ-004 FSM states SHALL be IDLE, GATE, LOAD and ACK, with a settle counter cnt of 8 bits.
REQ-005 In IDLE with no request sampled, the block SHALL set clk_en_o to run_en every cycle.
REQ-006 In IDLE with req_a or req_b sampled high at edge E0, the block SHALL at that same edge:
- latch the granted requester id;
- latch its ratio into a shadow register;
- set clk_en_o to 0 and cnt to 0;
- go to GATE.
REQ-007 Arbitration SHALL be round-robin:
- a single request wins;
- when both requests are high, the side named by the priority pointer wins;
- the pointer SHALL move to the other side after every grant.
REQ-008 In GATE, cnt SHALL increment every cycle; at the edge where cnt == SETTLE-1 the block SHALL load div_ratio_o from the shadow register and go to LOAD.
REQ-009 In LOAD, at the next edge the block SHALL:
- set clk_en_o to the current run_en;
- set the granted ack high;
- go to ACK.
REQ-010 In ACK, at the next edge the block SHALL clear the ack and return to IDLE.
REQ-011 Cycle timing relative to E0 SHALL be:
- clk_en_o low after E0;
- div_ratio_o updated after E0+SETTLE;
- ack high from E0+SETTLE+1 to E0+SETTLE+2;
- busy high for exactly SETTLE+2 cycles.
REQ-012 div_ratio_o SHALL never change while clk_en_o is 1.
REQ-013 Ratio-value rules:
- the requested ratio SHALL be forwarded unmodified, including 0 and 1 (divider bypass);
- a request equal to the current div_ratio_o SHALL still run the full sequence.
REQ-014 Request, ratio and run_en changes during GATE, LOAD or ACK SHALL NOT affect the active sequence; run_en is sampled only in LOAD and IDLE.
REQ-015 A requester SHALL drop req in the ack cycle; a req still high in IDLE after ACK SHALL be treated as a new request.
REQ-016 ack_a and ack_b SHALL never be high in the same cycle.

Reset
REQ-017 With rst high at a rising edge, the block SHALL enter IDLE and set:
- clk_en_o = 0, div_ratio_o = RESET_RATIO;
- ack_a = 0, ack_b = 0;
- cnt = 0, priority pointer = A.
REQ-018 Reset asserted mid-sequence SHALL abort it with no ack issued and no shadow ratio applied.
REQ-019 After reset releases, clk_en_o SHALL follow run_en starting at the first edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios (SETTLE=4):
- run_en=1, req_a with ratio_a=6 at E0 -> clk_en_o=0 after E0; div_ratio_o=6 after E0+4; clk_en_o=1 and ack_a=1 after E0+5; ack_a=0 and busy=0 after E0+6.
- req_a and req_b both high (ratios 3 and 10) after reset -> A granted first (div_ratio_o=3, ack_a); B granted next (div_ratio_o=10, ack_b); a following simultaneous pair is granted to A first again.
- rst pulsed at E0+2 of a sequence -> div_ratio_o=1, clk_en_o=0, no ack, busy=0.
- run_en=0 during the sequence, req_b with ratio_b=0 -> div_ratio_o=0, clk_en_o=0 after LOAD, ack_b pulses.
- Ratio_a toggled every cycle during GATE -> div_ratio_o equals the value latched at E0; a monitor asserts no div_ratio_o change while clk_en_o=1 for the whole run.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//
// Sequences ratio changes for a downstream clock divider. Two requesters
// (A and B) raise level requests carrying a new ratio; a round-robin arbiter
// grants one. The divider clock enable is dropped, held low for SETTLE
// cycles, the new ratio is applied, the enable is restored from run_en and
// the winner receives a one-cycle ack. Outside a sequence the enable simply
// follows run_en.
//
// Parameters
//   div_ratio_wd : width of every ratio port
//   SETTLE       : cycles clk_en_o stays low before the ratio update (1..255)
//   RESET_RATIO  : div_ratio_o after reset (1 = divider bypass)
//
// Ports
//   clk_ref     in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   run_en      in   software enable for the divider
//   req_a/b     in   ratio-change request levels, held until ack
//   ratio_a/b   in   requested ratio, valid while the matching req is high
//   ack_a/b     out  one-cycle completion pulses (registered)
//   busy        out  high while a change sequence is in progress
//   clk_en_o    out  divider clock enable (registered)
//   div_ratio_o out  divider ratio (registered)
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
   parameter int unsigned                div_ratio_wd = 8,
   parameter int unsigned                SETTLE       = 4,
   parameter logic [div_ratio_wd-1:0]    RESET_RATIO  = 1
) (
   input  logic                    clk_ref,
   input  logic                    rst,
   input  logic                    run_en,
   input  logic                    req_a,
   input  logic [div_ratio_wd-1:0] ratio_a,
   input  logic                    req_b,
   input  logic [div_ratio_wd-1:0] ratio_b,
   output logic                    ack_a,
   output logic                    ack_b,
   output logic                    busy,
   output logic                    clk_en_o,
   output logic [div_ratio_wd-1:0] div_ratio_o
);

   typedef enum logic [1:0] {
      IDLE,
      GATE,
      LOAD,
      ACK
   } state_t;

   // Last settle count value; the ratio is loaded on the edge that sees it.
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

   state_t                  state;
   state_t                  state_nxt;
   logic [7:0]              cnt;
   logic [7:0]              cnt_nxt;
   logic                    gnt_b;      // granted requester: 0 = A, 1 = B
   logic                    gnt_b_nxt;
   logic                    ptr_b;      // round-robin pointer: 0 = A, 1 = B
   logic                    ptr_b_nxt;
   logic [div_ratio_wd-1:0] shadow;
   logic [div_ratio_wd-1:0] shadow_nxt;
   logic [div_ratio_wd-1:0] div_nxt;
   logic                    clk_en_nxt;
   logic                    ack_a_nxt;
   logic                    ack_b_nxt;
   logic                    win_b;

   // B wins when it is the only requester, or both request and the pointer
   // favours B.
   assign win_b = req_b & (~req_a | ptr_b);

   assign busy = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      gnt_b_nxt  = gnt_b;
      ptr_b_nxt  = ptr_b;
      shadow_nxt = shadow;
      div_nxt    = div_ratio_o;
      clk_en_nxt = clk_en_o;
      ack_a_nxt  = 1'b0;
      ack_b_nxt  = 1'b0;

      unique case (state)
         IDLE: begin
            if (req_a | req_b) begin
               // Capture grant and ratio now so later input changes cannot
               // disturb the running sequence.
               gnt_b_nxt  = win_b;
               ptr_b_nxt  = ~win_b;
               shadow_nxt = win_b ? ratio_b : ratio_a;
               clk_en_nxt = 1'b0;
               cnt_nxt    = '0;
               state_nxt  = GATE;
            end else begin
               clk_en_nxt = run_en;
            end
         end

         GATE: begin
            cnt_nxt = cnt + 8'd1;
            if (cnt == SETTLE_LAST) begin
               // Enable is already low here, so the ratio never changes
               // while the divider is running.
               div_nxt   = shadow;
               state_nxt = LOAD;
            end
         end

         LOAD: begin
            clk_en_nxt = run_en;
            ack_a_nxt  = ~gnt_b;
            ack_b_nxt  = gnt_b;
            state_nxt  = ACK;
         end

         ACK: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_ref) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         gnt_b       <= 1'b0;
         ptr_b       <= 1'b0;
         shadow      <= '0;
         clk_en_o    <= 1'b0;
         div_ratio_o <= RESET_RATIO;
         ack_a       <= 1'b0;
         ack_b       <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         gnt_b       <= gnt_b_nxt;
         ptr_b       <= ptr_b_nxt;
         shadow      <= shadow_nxt;
         clk_en_o    <= clk_en_nxt;
         div_ratio_o <= div_nxt;
         ack_a       <= ack_a_nxt;
         ack_b       <= ack_b_nxt;
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Bench for clk_div_ctrl with SETTLE = 4. A table of request transactions is
// applied in a loop; each transaction pushes its expected grant/ratio/enable
// to a scoreboard queue that a monitor pops on every ack pulse. Hand-written
// sequences cover reset, exact cycle timing, reset abort, input churn during
// a sequence and a request held past its ack. A monitor also flags any
// ratio change while the enable is high and any double ack.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

   logic       clk_ref = 1'b0;
   logic       rst;
   logic       run_en;
   logic       req_a;
   logic [7:0] ratio_a;
   logic       req_b;
   logic [7:0] ratio_b;
   logic       ack_a;
   logic       ack_b;
   logic       busy;
   logic       clk_en_o;
   logic [7:0] div_ratio_o;

   clk_div_ctrl #(
      .div_ratio_wd (8),
      .SETTLE       (4),
      .RESET_RATIO  (8'd1)
   ) dut (
      .clk_ref     (clk_ref),
      .rst         (rst),
      .run_en      (run_en),
      .req_a       (req_a),
      .ratio_a     (ratio_a),
      .req_b       (req_b),
      .ratio_b     (ratio_b),
      .ack_a       (ack_a),
      .ack_b       (ack_b),
      .busy        (busy),
      .clk_en_o    (clk_en_o),
      .div_ratio_o (div_ratio_o)
   );

   always #5 clk_ref = ~clk_ref;

   typedef struct packed {
      logic       side_b;
      logic [7:0] ratio;
      logic       clk_en;
   } exp_t;

   typedef struct {
      logic       run;
      logic       ra;
      logic [7:0] rat_a;
      logic       rb;
      logic [7:0] rat_b;
      logic       exp_b;
      logic [7:0] exp_ratio;
   } vec_t;

   exp_t sb[$];
   vec_t vt[8];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_ref);
      #1;
   endtask

   // Bounded wait for the ack pulse, then drop requests and expect idle.
   task automatic wait_done(input string name);
      int n = 0;
      while (!(ack_a || ack_b) && n < 20) begin
         step();
         n++;
      end
      chk({name, "_ack_seen"}, 32'(ack_a | ack_b), 32'd1);
      req_a = 1'b0;
      req_b = 1'b0;
      step();
      chk({name, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   // Scoreboard and safety monitor.
   logic       prev_en  = 1'b0;
   logic [7:0] prev_div = 8'd0;
   always @(negedge clk_ref) begin
      exp_t e;
      if (!rst) begin
         if (ack_a && ack_b) begin
            n_err++;
            $display("FAIL double_ack: ack_a=%0b ack_b=%0b required not both", ack_a, ack_b);
         end
         if (ack_a || ack_b) begin
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_ack: ack_a=%0b ack_b=%0b required none", ack_a, ack_b);
            end else begin
               e = sb.pop_front();
               chk("ack_side", 32'(ack_b), 32'(e.side_b));
               chk("ack_ratio", 32'(div_ratio_o), 32'(e.ratio));
               chk("ack_clk_en", 32'(clk_en_o), 32'(e.clk_en));
            end
         end
         if (prev_en && clk_en_o && (div_ratio_o != prev_div)) begin
            n_err++;
            $display("FAIL ratio_while_enabled: ratio %0h -> %0h required stable", prev_div, div_ratio_o);
         end
      end
      prev_en  = clk_en_o;
      prev_div = div_ratio_o;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time %0t required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      //            run ra  rat_a  rb  rat_b   exp_b exp_ratio
      vt[0] = '{1'b1, 1'b1, 8'd3,   1'b1, 8'd10,  1'b0, 8'd3};
      vt[1] = '{1'b1, 1'b0, 8'd0,   1'b1, 8'd10,  1'b1, 8'd10};
      vt[2] = '{1'b1, 1'b1, 8'd7,   1'b1, 8'd9,   1'b0, 8'd7};
      vt[3] = '{1'b0, 1'b0, 8'd0,   1'b1, 8'd0,   1'b1, 8'd0};
      vt[4] = '{1'b1, 1'b1, 8'd1,   1'b0, 8'd0,   1'b0, 8'd1};
      vt[5] = '{1'b1, 1'b0, 8'd0,   1'b1, 8'd255, 1'b1, 8'd255};
      vt[6] = '{1'b1, 1'b1, 8'd255, 1'b0, 8'd0,   1'b0, 8'd255};
      vt[7] = '{1'b1, 1'b1, 8'd128, 1'b1, 8'd5,   1'b1, 8'd5};

      rst = 1'b1; run_en = 1'b0;
      req_a = 1'b0; ratio_a = 8'd0; req_b = 1'b0; ratio_b = 8'd0;

      // Reset state, then enable follows run_en from the first free edge.
      step(); step();
      chk("rst_clk_en", 32'(clk_en_o), 32'd0);
      chk("rst_ratio", 32'(div_ratio_o), 32'd1);
      chk("rst_ack_a", 32'(ack_a), 32'd0);
      chk("rst_ack_b", 32'(ack_b), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      run_en = 1'b1;
      rst = 1'b0;
      step();
      chk("rel_clk_en", 32'(clk_en_o), 32'd1);

      // Exact timing of one A request, ratio 6.
      ratio_a = 8'd6; req_a = 1'b1;
      sb.push_back('{1'b0, 8'd6, 1'b1});
      step();
      chk("t_e0_busy", 32'(busy), 32'd1);
      chk("t_e0_clk_en", 32'(clk_en_o), 32'd0);
      chk("t_e0_ratio", 32'(div_ratio_o), 32'd1);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("t_e%0d_ratio", k), 32'(div_ratio_o), 32'd1);
         chk($sformatf("t_e%0d_clk_en", k), 32'(clk_en_o), 32'd0);
         chk($sformatf("t_e%0d_ack", k), 32'(ack_a), 32'd0);
      end
      step();
      chk("t_e4_ratio", 32'(div_ratio_o), 32'd6);
      chk("t_e4_clk_en", 32'(clk_en_o), 32'd0);
      chk("t_e4_ack", 32'(ack_a), 32'd0);
      step();
      chk("t_e5_clk_en", 32'(clk_en_o), 32'd1);
      chk("t_e5_ack", 32'(ack_a), 32'd1);
      chk("t_e5_busy", 32'(busy), 32'd1);
      req_a = 1'b0;
      step();
      chk("t_e6_ack", 32'(ack_a), 32'd0);
      chk("t_e6_busy", 32'(busy), 32'd0);
      step();
      chk("t_e7_clk_en", 32'(clk_en_o), 32'd1);

      // Reset pulsed at E0+2 aborts the sequence.
      ratio_a = 8'd42; req_a = 1'b1;
      step(); step();
      rst = 1'b1; req_a = 1'b0;
      step();
      chk("abort_ratio", 32'(div_ratio_o), 32'd1);
      chk("abort_clk_en", 32'(clk_en_o), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ack", 32'({ack_a, ack_b}), 32'd0);
      rst = 1'b0;
      repeat (8) step();
      chk("abort_ratio_later", 32'(div_ratio_o), 32'd1);
      chk("abort_clk_en_later", 32'(clk_en_o), 32'd1);

      // Table of transactions; round-robin pointer starts at A after reset.
      for (int i = 0; i < 8; i++) begin
         run_en  = vt[i].run;
         req_a   = vt[i].ra;
         ratio_a = vt[i].rat_a;
         req_b   = vt[i].rb;
         ratio_b = vt[i].rat_b;
         sb.push_back('{vt[i].exp_b, vt[i].exp_ratio, vt[i].run});
         step();
         chk($sformatf("v%0d_busy_e0", i), 32'(busy), 32'd1);
         chk($sformatf("v%0d_clk_en_e0", i), 32'(clk_en_o), 32'd0);
         n = 1;
         for (int k = 0; k < 20 && busy; k++) begin
            if (ack_a || ack_b) begin
               req_a = 1'b0;
               req_b = 1'b0;
            end
            step();
            if (busy) n++;
         end
         chk($sformatf("v%0d_busy_len", i), 32'(n), 32'd6);
         chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
         req_a = 1'b0;
         req_b = 1'b0;
         step();
      end

      // Ratio and run_en churn during GATE must not leak into the result.
      run_en = 1'b0; ratio_a = 8'h21; req_a = 1'b1;
      sb.push_back('{1'b0, 8'h21, 1'b1});
      step();
      for (int k = 1; k <= 4; k++) begin
         ratio_a = ~ratio_a;
         run_en  = 1'(k & 1);
         step();
         chk($sformatf("churn_e%0d_clk_en", k), 32'(clk_en_o), 32'd0);
      end
      chk("churn_ratio", 32'(div_ratio_o), 32'h21);
      run_en = 1'b1;
      wait_done("churn");

      // Request held past its ack is served again as a new request.
      ratio_a = 8'd9; req_a = 1'b1;
      sb.push_back('{1'b0, 8'd9, 1'b1});
      sb.push_back('{1'b0, 8'd9, 1'b1});
      step();
      repeat (5) step();
      chk("held_first_ack", 32'(ack_a), 32'd1);
      step();
      chk("held_gap_busy", 32'(busy), 32'd0);
      step();
      chk("held_rereq_busy", 32'(busy), 32'd1);
      chk("held_rereq_clk_en", 32'(clk_en_o), 32'd0);
      wait_done("held2");

      step(); step();
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
